lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- CPU-side load/store unit for the rv32i core; it is the initiator that drives the data_mem port (mem_read, mem_write, load_op, store_op, mem_addr, data_mem_i) and consumes data_mem_o.
- Accepts one load/store per valid/ready handshake from the execute stage.
- Computes the effective address and sequences the memory access, honouring the memory's read latency.
- Returns a completion response with a valid/ready handshake to the writeback stage.

Parameters:
ADDR_W, 12, width of mem_addr; effective address truncated to this width
RD_LAT, 1, cycles from mem_read/mem_addr asserted to data_mem_o valid (1..4)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_is_load  in  1  request is a load
req_is_store  in  1  request is a store
req_funct3  in  3  RV32I funct3 (size/sign)
req_base  in  32  rs1 value
req_imm  in  12  signed offset
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
rsp_valid  out  1  response present
rsp_ready  in  1  writeback accepts response
rsp_rdata  out  32  raw data_mem_o captured for loads; 0 for stores/faults
rsp_rd  out  5  destination tag; 0 for stores
rsp_fault  out  1  request faulted; no memory side effect
mem_read  out  1  to data_mem
mem_write  out  1  to data_mem
load_op  out  6  one-hot: [0]LB [1]LH [2]LW [3]LBU [4]LHU [5]reserved(0)
store_op  out  6  one-hot: [0]SB [1]SH [2]SW [5:3]=0
mem_addr  out  ADDR_W  effective address
data_mem_i  out  32  store data to memory
data_mem_o  in  32  load data from memory

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, except req_ready=1.
- FSM states: IDLE, WRITE, READ_WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted on a clk edge with req_valid&req_ready; request fields are registered at that edge.
- Effective address:
  - ea = req_base + sign_extend(req_imm), computed mod 2^32.
  - mem_addr = ea[ADDR_W-1:0]; upper bits are dropped silently.
- Decode, applied at acceptance:
  - is_load&is_store both high, or both low: fault.
  - Load funct3 000/001/010/100/101 map to LB/LH/LW/LBU/LHU. Load funct3 011/110/111: fault.
  - Store funct3 000/001/010 map to SB/SH/SW. Store funct3 ≥011: fault.
- Fault path: IDLE -> RESP directly. rsp_fault=1, rsp_rdata=0, no mem_read/mem_write pulse.
- Store path:
  - IDLE -> WRITE for exactly 1 cycle; drive mem_write=1, store_op, mem_addr, data_mem_i=wdata.
  - Then RESP with rsp_fault=0, rsp_rdata=0, rsp_rd=0.
- Load path:
  - IDLE -> READ_WAIT; hold mem_read=1, load_op and mem_addr stable for RD_LAT cycles.
  - Capture data_mem_o on the final READ_WAIT edge, then go to RESP. rsp_rdata=captured value, rsp_rd=req_rd.
- mem_read, mem_write, load_op, store_op are 0 in every state other than those listed above. data_mem_i and mem_addr hold their last value.
- RESP: rsp_valid=1, fields stable until rsp_valid&rsp_ready, then IDLE. No new request is accepted in the same cycle, giving a minimum 1-cycle bubble.
- Throughput:
  - Store: 3 cycles accept-to-IDLE with immediate rsp_ready.
  - Load: 2+RD_LAT cycles.
- rst asserted mid-operation: immediate return to IDLE. An in-flight mem_write/mem_read is deasserted asynchronously and the response is discarded.
- Sign/zero extension of load data is performed by data_mem per load_op; this unit passes data_mem_o unmodified.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined:
  - LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]≠00, is a fault (fault path, no memory access).
  - Byte accesses are never misaligned.
- Undefined: no alignment check; the access is issued with the unaligned mem_addr as computed.

Test Plan:
1. Reset: rst=1 asynchronously mid-cycle -> all outputs 0, req_ready=1 with no clock edge needed.
2. SW: base=0x00000550, imm=0x005, wdata=0x12345678, funct3=010.
   - Without the macro: one-cycle mem_write=1, store_op=6'b000100, mem_addr=0x555, data_mem_i=0x12345678, then rsp_valid with fault=0.
   - With LSU_ALIGN_CHECK_EN: fault=1 and mem_write never asserted.
3. LW after SW at base=0x554, imm=0, RD_LAT=1, memory model returns 0x12345678 -> mem_read high 1 cycle, load_op=6'b000100, rsp_rdata=0x12345678, rsp_rd=req_rd.
4. Negative offset wrap: base=0x00000002, imm=0xFFE (-2), LBU -> ea=0x00000000, mem_addr=0x000, load_op=6'b001000. Second case: base=0xFFFFF00F, imm=0, LB -> mem_addr=0x00F.
5. Backpressure: rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata held constant, req_ready=0 throughout, no further mem_read. Set rsp_ready=1 -> IDLE on the next edge.
6. Illegal decode: is_load=1 with funct3=011, then is_load=is_store=1 -> rsp_fault=1 for each, with zero mem_read/mem_write pulses. Then rst pulse during READ_WAIT with RD_LAT=3 -> mem_read drops immediately and no rsp_valid is produced.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store unit initiator for the rv32i data_mem port.
// Accepts one load/store per req handshake, computes the effective address,
// drives mem_read/mem_write for the access and returns a response on rsp_*.
// Optional feature macro: LSU_ALIGN_CHECK_EN (faults misaligned half/word accesses).
// Faulted requests report rsp_rd=0 so writeback never updates a register for them.
module lsu_mem_initiator #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_imm,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [5:0]        load_op,
  output logic [5:0]        store_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       data_mem_i,
  input  logic [31:0]       data_mem_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      state;
  logic [1:0]  lat_cnt;
  logic [4:0]  rd_tag;
  logic [31:0] ea;
  logic [5:0]  dec_load_op;
  logic [5:0]  dec_store_op;
  logic        dec_fault;
  logic        ea_unused;

  // Upper effective-address bits are deliberately dropped.
  assign ea_unused = ^ea[31:ADDR_W];

  // Effective address and request decode, evaluated against the live request.
  always_comb begin
    ea           = req_base + {{20{req_imm[11]}}, req_imm};
    dec_load_op  = '0;
    dec_store_op = '0;
    dec_fault    = 1'b0;
    if (req_is_load == req_is_store) begin
      dec_fault = 1'b1;
    end else if (req_is_load) begin
      case (req_funct3)
        3'b000:  dec_load_op = 6'b000001;
        3'b001:  dec_load_op = 6'b000010;
        3'b010:  dec_load_op = 6'b000100;
        3'b100:  dec_load_op = 6'b001000;
        3'b101:  dec_load_op = 6'b010000;
        default: dec_fault   = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  dec_store_op = 6'b000001;
        3'b001:  dec_store_op = 6'b000010;
        3'b010:  dec_store_op = 6'b000100;
        default: dec_fault    = 1'b1;
      endcase
    end
`ifdef LSU_ALIGN_CHECK_EN
    if (!dec_fault) begin
      if ((dec_load_op[1] | dec_load_op[4] | dec_store_op[1]) && ea[0])
        dec_fault = 1'b1;
      if ((dec_load_op[2] | dec_store_op[2]) && (ea[1:0] != 2'b00))
        dec_fault = 1'b1;
    end
`endif
  end

  // Access sequencer with registered memory-side and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_rd     <= '0;
      rsp_fault  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      load_op    <= '0;
      store_op   <= '0;
      mem_addr   <= '0;
      data_mem_i <= '0;
      lat_cnt    <= '0;
      rd_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_fault) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
              rsp_rd    <= '0;
            end else if (req_is_store) begin
              state      <= WRITE;
              mem_write  <= 1'b1;
              store_op   <= dec_store_op;
              mem_addr   <= ea[ADDR_W-1:0];
              data_mem_i <= req_wdata;
            end else begin
              state    <= READ_WAIT;
              mem_read <= 1'b1;
              load_op  <= dec_load_op;
              mem_addr <= ea[ADDR_W-1:0];
              lat_cnt  <= '0;
              rd_tag   <= req_rd;
            end
          end
        end
        WRITE: begin
          state     <= RESP;
          mem_write <= 1'b0;
          store_op  <= '0;
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_rdata <= '0;
          rsp_rd    <= '0;
        end
        READ_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state     <= RESP;
            mem_read  <= 1'b0;
            load_op   <= '0;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= data_mem_o;
            rsp_rd    <= rd_tag;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed vector table, randomized requests
// against a spec-level model, async reset checks, and a data_mem model whose
// read data is only correct on the cycle RD_LAT cycles into a read.
module tb_lsu_mem_initiator;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 3;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_wdata;
  logic [11:0] req_imm;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        mem_read, mem_write;
  logic [5:0]  load_op, store_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] data_mem_i, data_mem_o;

  lsu_mem_initiator #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_fault(rsp_fault),
    .mem_read(mem_read), .mem_write(mem_write),
    .load_op(load_op), .store_op(store_op),
    .mem_addr(mem_addr), .data_mem_i(data_mem_i), .data_mem_o(data_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          hold;
    logic        fault;
    logic [5:0]  op;
    logic [11:0] addr;
    logic [31:0] rdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return {a, 8'h5A, a};
  endfunction

  // data_mem model: word store, raw read valid only on the RD_LAT-th read cycle
  logic [31:0] mem [0:4095];
  logic        written [0:4095];
  logic        mem_clr;
  int          rcnt;
  logic [31:0] ref_mem [0:4095];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
    end else if (mem_write) begin
      mem[mem_addr]     <= data_mem_i;
      written[mem_addr] <= 1'b1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rcnt <= 0;
    else if (mem_read) rcnt <= rcnt + 1;
    else rcnt <= 0;
  end

  always_comb begin
    data_mem_o = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
    if (!(mem_read && rcnt == RD_LAT - 1)) data_mem_o = ~data_mem_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference decode straight from the ISA tables
  task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [11:0] imm,
                       output logic fault, output logic [5:0] op, output logic [11:0] addr);
    int lidx [8] = '{0, 1, 2, -1, 3, 4, -1, -1};
    int sidx [8] = '{0, 1, 2, -1, -1, -1, -1, -1};
    int lsz  [8] = '{1, 2, 4, 0, 1, 2, 0, 0};
    logic [31:0] ea;
    int idx;
    ea    = base + {{20{imm[11]}}, imm};
    idx   = ld ? lidx[f3] : sidx[f3];
    fault = (ld == st) || (idx < 0);
    if (!fault && ALIGN && (ea % lsz[f3]) != 0) fault = 1'b1;
    op   = fault ? 6'd0 : 6'(1 << idx);
    addr = ea[11:0];
  endtask

  task automatic run_txn(input vec_t v);
    int cyc, nrd, nwr, exp_lat;
    logic [5:0]  op_or;
    logic [11:0] a_seen;
    logic [31:0] wd_seen;
    logic        a_bad, rdy_bad, stable_bad;
    logic [38:0] snap;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_is_load = v.ld; req_is_store = v.st; req_funct3 = v.f3;
    req_base = v.base; req_imm = v.imm; req_wdata = v.wd; req_rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0; req_is_load = $urandom; req_is_store = $urandom;
    req_funct3 = 3'($urandom); req_base = $urandom; req_imm = 12'($urandom);
    req_wdata = $urandom; req_rd = 5'($urandom);
    cyc = 1; nrd = 0; nwr = 0; op_or = '0; a_seen = '0; wd_seen = '0;
    a_bad = 1'b0; rdy_bad = 1'b0;
    while (!rsp_valid && cyc <= 20) begin
      if (mem_read) begin
        nrd++;
        op_or |= load_op;
        if (nrd == 1) a_seen = mem_addr;
        else if (mem_addr != a_seen) a_bad = 1'b1;
      end
      if (mem_write) begin
        nwr++;
        op_or  |= store_op;
        a_seen  = mem_addr;
        wd_seen = data_mem_i;
      end
      if (req_ready) rdy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    exp_lat = v.fault ? 1 : (v.st ? 2 : 1 + RD_LAT);
    chk("rsp_latency", cyc, exp_lat);
    chk("mem_read_cycles", nrd, (!v.fault && v.ld) ? RD_LAT : 0);
    chk("mem_write_cycles", nwr, (!v.fault && v.st) ? 1 : 0);
    if (!v.fault) begin
      chk("mem_op", op_or, v.op);
      chk("mem_addr", a_bad ? 32'hFFFF_FFFF : a_seen, v.addr);
    end
    if (!v.fault && v.st) chk("data_mem_i", wd_seen, v.wd);
    chk("rsp_fault", rsp_fault, v.fault);
    chk("rsp_rdata", rsp_rdata, v.rdata);
    chk("rsp_rd", rsp_rd, (v.ld && !v.st && !v.fault) ? v.rd : 5'd0);
    chk("req_ready_busy", rdy_bad | req_ready, 0);
    chk("resp_no_mem", {mem_read, mem_write, load_op, store_op}, 0);
    snap = {rsp_valid, rsp_fault, rsp_rd, rsp_rdata};
    stable_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_fault, rsp_rd, rsp_rdata} != snap || req_ready || mem_read || mem_write)
        stable_bad = 1'b1;
    end
    if (v.hold > 0) chk("backpressure_hold", stable_bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_release", {rsp_valid, req_ready}, 2'b01);
    if (v.st && !v.ld && !v.fault) ref_mem[v.addr] = v.wd;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   k;
    logic bad;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(12'(i));
    rst = 1'b0; mem_clr = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_base = '0; req_imm = '0; req_wdata = '0; req_rd = '0;

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("reset_ctrl", {mem_read, mem_write, load_op, store_op, rsp_valid, rsp_fault, rsp_rd}, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_data_mem_i", data_mem_i, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    #4 mem_clr = 1'b0; rst = 1'b0;

    //            ld    st    f3    base           imm      wdata          rd hold fault                  op         addr     rdata
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_0550, 12'h005, 32'h1234_5678, 5'd0, 0, ALIGN, 6'b000100, 12'h555, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_0554, 12'h000, 32'h1234_5678, 5'd0, 0, 1'b0,  6'b000100, 12'h554, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0554, 12'h000, 32'h0,         5'd7, 5, 1'b0,  6'b000100, 12'h554, 32'h1234_5678});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_0000, 12'h000, 32'hA5A5_0001, 5'd0, 0, 1'b0,  6'b000100, 12'h000, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0002, 12'hFFE, 32'h0,         5'd3, 1, 1'b0,  6'b001000, 12'h000, 32'hA5A5_0001});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_000F, 12'h000, 32'h0000_0077, 5'd0, 0, 1'b0,  6'b000001, 12'h00F, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'hFFFF_F00F, 12'h000, 32'h0,         5'd4, 0, 1'b0,  6'b000001, 12'h00F, 32'h0000_0077});
    tbl.push_back('{1'b1, 1'b0, 3'd3, 32'h0000_0100, 12'h000, 32'h0,         5'd9, 0, 1'b1,  6'b000000, 12'h100, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h0000_0100, 12'h000, 32'h0,         5'd9, 2, 1'b1,  6'b000000, 12'h100, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 3'd2, 32'h0000_0100, 12'h000, 32'h0,         5'd9, 0, 1'b1,  6'b000000, 12'h100, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'h0000_0100, 12'h000, 32'h0,         5'd0, 0, 1'b1,  6'b000000, 12'h100, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_0100, 12'h001, 32'h0000_BEEF, 5'd0, 0, 1'b0,  6'b000001, 12'h101, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h0000_0101, 12'h000, 32'h0,         5'd5, 0, ALIGN, 6'b000010, 12'h101, ALIGN ? 32'h0 : 32'h0000_BEEF});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h1234_5000, 12'h7FC, 32'hCAFE_0800, 5'd0, 2, 1'b0,  6'b000100, 12'h7FC, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_1000, 12'h7FC, 32'h0,         5'd8, 0, 1'b0,  6'b000100, 12'h7FC, 32'hCAFE_0800});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 32'h0000_1000, 12'h800, 32'h0,         5'd6, 0, 1'b0,  6'b010000, 12'h800, 32'h8005_A800});

    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

    // async reset while a load is waiting on memory: no response may follow
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2;
    req_base = 32'h554; req_imm = '0; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    chk("read_wait_mem_read", mem_read, 1);
    #1 rst = 1'b1;
    #1;
    chk("midop_reset_ctrl", {mem_read, mem_write, load_op, store_op, rsp_valid, rsp_fault, rsp_rd}, 0);
    chk("midop_reset_req_ready", req_ready, 1);
    chk("midop_reset_mem_addr", mem_addr, 0);
    #1 rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_read || !req_ready) bad = 1'b1;
    end
    chk("midop_reset_no_rsp", bad, 0);
    run_txn(tbl[2]);

    // randomized requests against the model
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 9);
      v.ld = (k <= 3) || (k == 8);
      v.st = (k >= 4) && (k <= 8);
      v.f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) v.f3 = 3'($urandom_range(0, 2));
      v.base = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      v.imm  = 12'($urandom_range(0, 15)) - 12'd4;
      v.wd   = $urandom;
      v.rd   = 5'($urandom_range(1, 31));
      v.hold = $urandom_range(0, 3);
      model(v.ld, v.st, v.f3, v.base, v.imm, v.fault, v.op, v.addr);
      v.rdata = (v.ld && !v.st && !v.fault) ? ref_mem[v.addr] : 32'h0;
      run_txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
